// File: rtl/refclk_seq_pkg.sv
// Shared state codes and counter sizing for the reference-clock output-buffer enable sequencer.
package refclk_seq_pkg;

  localparam logic [2:0] ST_OFF       = 3'd0;
  localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
  localparam logic [2:0] ST_SETTLE    = 3'd2;
  localparam logic [2:0] ST_ON        = 3'd3;
  localparam logic [2:0] ST_HOLDOFF   = 3'd4;

  // Wide enough to hold the largest of the three terminal counts.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/refclk_seq_timer.sv
// Clear/increment counter with a terminal-count compare; saturates instead of wrapping.
module refclk_seq_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  input  logic [W-1:0] term,
  output logic         at_term
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign at_term = (cnt == term);

endmodule

// File: rtl/refclk_obuf_enable_seq.sv
// Sequences the active-low CEB of a GT reference-clock output buffer from lock status and a
// software enable. One shared timer serves as lock filter, settle timer and holdoff timer.
module refclk_obuf_enable_seq
  import refclk_seq_pkg::*;
#(
  parameter int LOCK_FILTER    = 4,
  parameter int SETTLE_CYCLES  = 1024,
  parameter int HOLDOFF_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en_req,
  input  logic       lock_in,
  output logic       ceb_out,
  output logic       active,
  output logic       lock_lost,
  output logic [2:0] state_o
);

  localparam int W = cnt_width(LOCK_FILTER, SETTLE_CYCLES, HOLDOFF_CYCLES);

  if (LOCK_FILTER < 1) begin : g_bad_lock_filter
    $error("LOCK_FILTER must be >= 1");
  end
  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("SETTLE_CYCLES must be >= 1");
  end
  if (HOLDOFF_CYCLES < 1) begin : g_bad_holdoff
    $error("HOLDOFF_CYCLES must be >= 1");
  end

  logic [2:0]   state;
  logic [2:0]   next_state;
  logic         tmr_clear;
  logic         tmr_inc;
  logic         tmr_at_term;
  logic [W-1:0] tmr_term;
  logic         ceb_d;
  logic         active_d;
  logic         lock_lost_d;

  // Terminal is one below the target: the transition happens on the edge that would reach it.
  always_comb begin
    tmr_term = '0;
    case (state)
      ST_WAIT_LOCK: tmr_term = W'(LOCK_FILTER - 1);
      ST_SETTLE:    tmr_term = W'(SETTLE_CYCLES - 1);
      ST_HOLDOFF:   tmr_term = W'(HOLDOFF_CYCLES - 1);
      default:      tmr_term = '0;
    endcase
  end

  refclk_seq_timer #(
    .W(W)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmr_clear),
    .inc     (tmr_inc),
    .term    (tmr_term),
    .at_term (tmr_at_term)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_OFF;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    tmr_clear  = 1'b0;
    tmr_inc    = 1'b0;
    case (state)
      ST_OFF: begin
        tmr_clear = 1'b1;
        if (en_req) next_state = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (!en_req) begin
          next_state = ST_OFF;
          tmr_clear  = 1'b1;
        end else if (!lock_in) begin
          tmr_clear = 1'b1;
        end else if (tmr_at_term) begin
          next_state = ST_SETTLE;
          tmr_clear  = 1'b1;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (!en_req) begin
          next_state = ST_OFF;
          tmr_clear  = 1'b1;
        end else if (!lock_in) begin
          next_state = ST_WAIT_LOCK;
          tmr_clear  = 1'b1;
        end else if (tmr_at_term) begin
          next_state = ST_ON;
          tmr_clear  = 1'b1;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      ST_ON: begin
        tmr_clear = 1'b1;
        if (!en_req || !lock_in) next_state = ST_HOLDOFF;
      end
      ST_HOLDOFF: begin
        // en_req is only looked at when the holdoff expires, so toggling cannot shorten it.
        if (tmr_at_term) begin
          next_state = en_req ? ST_WAIT_LOCK : ST_OFF;
          tmr_clear  = 1'b1;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      default: begin
        next_state = ST_HOLDOFF;
        tmr_clear  = 1'b1;
      end
    endcase
  end

  always_comb begin
    ceb_d       = (next_state != ST_ON);
    active_d    = (next_state == ST_ON);
    lock_lost_d = (state == ST_ON) && !lock_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ceb_out   <= 1'b1;
      active    <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      ceb_out   <= ceb_d;
      active    <= active_d;
      lock_lost <= lock_lost_d;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_refclk_obuf_enable_seq.sv
// Bench for refclk_obuf_enable_seq: directed vector table, hand-written corner sequences,
// then randomized traffic against a behavioural model of the sequencing rules.
module tb_refclk_obuf_enable_seq;

  localparam int LF = 2;
  localparam int SC = 8;
  localparam int HC = 4;

  logic       clk;
  logic       reset;
  logic       en_req;
  logic       lock_in;
  logic       ceb_out;
  logic       active;
  logic       lock_lost;
  logic [2:0] state_o;

  int n_vec;
  int n_fail;

  refclk_obuf_enable_seq #(
    .LOCK_FILTER   (LF),
    .SETTLE_CYCLES (SC),
    .HOLDOFF_CYCLES(HC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en_req   (en_req),
    .lock_in  (lock_in),
    .ceb_out  (ceb_out),
    .active   (active),
    .lock_lost(lock_lost),
    .state_o  (state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural model: phase 0 off, 1 waiting for lock, 2 settling, 3 driving, 4 holdoff
  int m_st;
  int m_run;
  int m_el;
  bit m_lost;

  task automatic model_step(input bit r, input bit e, input bit l);
    m_lost = 1'b0;
    if (r) begin
      m_st = 0; m_run = 0; m_el = 0;
    end else begin
      case (m_st)
        0: if (e) begin m_st = 1; m_run = 0; end
        1: begin
          if (!e) m_st = 0;
          else if (!l) m_run = 0;
          else begin
            m_run++;
            if (m_run == LF) begin m_st = 2; m_el = 0; end
          end
        end
        2: begin
          if (!e) m_st = 0;
          else if (!l) begin m_st = 1; m_run = 0; end
          else begin
            m_el++;
            if (m_el == SC) m_st = 3;
          end
        end
        3: if (!e || !l) begin m_st = 4; m_el = 0; m_lost = !l; end
        default: begin
          m_el++;
          if (m_el == HC) begin m_st = e ? 1 : 0; m_run = 0; end
        end
      endcase
    end
  endtask

  // driver: apply inputs, take one rising edge, sample 1 time unit later
  task automatic tick(input bit r, input bit e, input bit l);
    reset = r; en_req = e; lock_in = l;
    @(posedge clk);
    #1;
    model_step(r, e, l);
  endtask

  // scoreboard compare
  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit r, e, l;
    bit ceb, act, lost;
    logic [2:0] st;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input bit r, input bit e, input bit l,
                              input bit ceb, input bit act, input bit lost, input int st);
    vec_t v;
    v.r = r; v.e = e; v.l = l;
    v.ceb = ceb; v.act = act; v.lost = lost; v.st = 3'(st);
    vecs.push_back(v);
  endfunction

  // full enable from OFF with lock high: ON on the 11th edge
  function automatic void add_bringup();
    add(0, 1, 1, 1, 0, 0, 1);
    add(0, 1, 1, 1, 0, 0, 1);
    for (int i = 0; i < SC; i++) add(0, 1, 1, 1, 0, 0, 2);
    add(0, 1, 1, 0, 1, 0, 3);
  endfunction

  initial begin
    n_vec = 0; n_fail = 0;
    reset = 1'b1; en_req = 1'b0; lock_in = 1'b0;
    m_st = 0; m_run = 0; m_el = 0; m_lost = 1'b0;

    // reset, bring-up latency, simultaneous lock+enable drop, holdoff to OFF
    add(1, 0, 0, 1, 0, 0, 0);
    add(0, 0, 1, 1, 0, 0, 0);
    add_bringup();
    add(0, 1, 1, 0, 1, 0, 3);
    add(0, 0, 0, 1, 0, 1, 4);
    for (int i = 0; i < HC - 1; i++) add(0, 0, 0, 1, 0, 0, 4);
    add(0, 0, 0, 1, 0, 0, 0);
    // reset in SETTLE, then a clean full bring-up proves counters restarted
    add(0, 1, 1, 1, 0, 0, 1);
    add(0, 1, 1, 1, 0, 0, 1);
    add(0, 1, 1, 1, 0, 0, 2);
    add(0, 1, 1, 1, 0, 0, 2);
    add(1, 1, 1, 1, 0, 0, 0);
    add_bringup();
    // reset in ON while lock is lost: no lock_lost pulse
    add(1, 1, 0, 1, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      tick(vecs[i].r, vecs[i].e, vecs[i].l);
      check($sformatf("vec%0d_ceb", i),   ceb_out,   vecs[i].ceb);
      check($sformatf("vec%0d_act", i),   active,    vecs[i].act);
      check($sformatf("vec%0d_lost", i),  lock_lost, vecs[i].lost);
      check($sformatf("vec%0d_state", i), state_o,   vecs[i].st);
    end

    // lock chatter in WAIT_LOCK restarts the filter
    tick(0, 1, 1); check("chat_enter", state_o, 1);
    tick(0, 1, 1); check("chat_hi1", state_o, 1);
    tick(0, 1, 0); check("chat_lo", state_o, 1);
    tick(0, 1, 1); check("chat_hi2", state_o, 1);
    tick(0, 1, 1); check("chat_settle", state_o, 2);

    // lock drop part-way through SETTLE returns to WAIT_LOCK quietly
    for (int i = 0; i < 4; i++) tick(0, 1, 1);
    check("settle_mid", state_o, 2);
    tick(0, 1, 0);
    check("settle_drop_state", state_o, 1);
    check("settle_drop_ceb", ceb_out, 1);
    check("settle_drop_lost", lock_lost, 0);

    // en_req blip in ON: full holdoff, then a fresh lock/settle sequence
    for (int i = 0; i < LF + SC; i++) tick(0, 1, 1);
    check("blip_on_state", state_o, 3);
    check("blip_on_ceb", ceb_out, 0);
    tick(0, 0, 1);
    check("blip_drop_ceb", ceb_out, 1);
    check("blip_drop_lost", lock_lost, 0);
    check("blip_drop_state", state_o, 4);
    for (int i = 1; i < HC + LF + SC; i++) begin
      tick(0, 1, 1);
      check($sformatf("blip_ceb_e%0d", i), ceb_out, 1);
      if (i < HC) check($sformatf("blip_hold_e%0d", i), state_o, 4);
      if (i == HC) check("blip_wait", state_o, 1);
    end
    tick(0, 1, 1);
    check("blip_reon_ceb", ceb_out, 0);
    check("blip_reon_state", state_o, 3);

    // randomized traffic against the model
    tick(1, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      bit r, e, l;
      r = ($urandom_range(0, 199) == 0);
      e = ($urandom_range(0, 15) != 0);
      l = ($urandom_range(0, 31) != 0);
      tick(r, e, l);
      check("rnd_state", state_o, m_st);
      check("rnd_ceb", ceb_out, (m_st != 3));
      check("rnd_act", active, (m_st == 3));
      check("rnd_lost", lock_lost, m_lost);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
